echo_voice_arbiter: RTL and testbench

//  Shares one sound-channel voice between the live MIDI note stream and the echo generator output.

---
 rtl/genmidi_pkg.sv | 28 ++
 rtl/echo_evt_fifo.sv | 57 +++++
 rtl/echo_voice_arbiter.sv | 177 +++++++++++++++++
 tb/tb_echo_voice_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/genmidi_pkg.sv
// Shared event type, voice ownership states and defaults for the echo/live voice path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package genmidi_pkg;

    // One voice event: note state plus the controller values that travel with it.
    typedef struct packed {
        logic       on;
        logic [6:0] note;
        logic [6:0] vel;
        logic [8:0] pb;
        logic [1:0] cc1;
        logic [6:0] cc1mod;
    } voice_evt_t;

    // Which source currently owns the voice.
    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_LIVE = 2'd1,
        OWN_ECHO = 2'd2
    } owner_e;

    localparam logic [6:0] CC1MOD_DEFAULT = 7'd127;

    // Idle event: everything zero except full mod-wheel depth.
    localparam voice_evt_t EVT_RESET = {1'b0, 7'd0, 7'd0, 9'd0, 2'd0, CC1MOD_DEFAULT};

endpackage

// File: rtl/echo_evt_fifo.sv
// Synchronous FIFO of voice events with one extra pointer bit to tell full from empty.
// Latency: a pushed entry is visible at the head on the following cycle.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module echo_evt_fifo
    import genmidi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  voice_evt_t push_dat,
    input  logic       pop,
    output voice_evt_t pop_dat,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    voice_evt_t    mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          wr_en;
    logic          rd_en;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];

    // A pop in the same cycle frees the slot the push lands in, so a full FIFO still accepts.
    always_comb begin
        rd_en    = pop && !empty;
        wr_en    = push && (!full || rd_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (rd_en) rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end

    // Pointer registers; storage contents are don't-care until written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage written at the tail.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/echo_voice_arbiter.sv
// Arbitrates one voice between live MIDI events (priority) and queued echo change events.
// Latency: live_valid -> out_valid 1 cycle; echo change -> out_valid 2 cycles (when idle).
// Backpressure: output held while out_ready low; live slot overwrites, echo FIFO drops and counts.
module echo_voice_arbiter
    import genmidi_pkg::*;
#(
    parameter int ECHO_DEPTH = 4,
    parameter int DROP_W     = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              live_valid,
    input  logic              live_on,
    input  logic [6:0]        live_note,
    input  logic [6:0]        live_vel,
    input  logic [8:0]        live_pb,
    input  logic [1:0]        live_cc1,
    input  logic [6:0]        live_cc1mod,
    input  logic              echo_on,
    input  logic [6:0]        echo_note,
    input  logic [6:0]        echo_vel,
    input  logic [8:0]        echo_pb,
    input  logic [1:0]        echo_cc1,
    input  logic [6:0]        echo_cc1mod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_on,
    output logic [6:0]        out_note,
    output logic [6:0]        out_vel,
    output logic [8:0]        out_pb,
    output logic [1:0]        out_cc1,
    output logic [6:0]        out_cc1mod,
    output logic              out_src,
    output logic [1:0]        owner,
    output logic [DROP_W-1:0] drop_cnt
);
    voice_evt_t        live_in, echo_in, live_cand, fifo_head;
    voice_evt_t        shadow_q, shadow_d;
    voice_evt_t        live_evt_q, live_evt_d;
    voice_evt_t        out_evt_q, out_evt_d;
    logic              live_pend_q, live_pend_d;
    logic              out_valid_q, out_valid_d;
    logic              out_src_q, out_src_d;
    owner_e            owner_q, owner_d;
    logic [6:0]        owner_note_q, owner_note_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic              echo_chg, slot_free, live_has, keep;

    assign live_in = {live_on, live_note, live_vel, live_pb, live_cc1, live_cc1mod};
    assign echo_in = {echo_on, echo_note, echo_vel, echo_pb, echo_cc1, echo_cc1mod};

    echo_evt_fifo #(.DEPTH(ECHO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (fifo_push),
        .push_dat (echo_in),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Capture, issue with live priority, ownership filtering and owner next-state.
    always_comb begin
        shadow_d     = shadow_q;
        live_evt_d   = live_evt_q;
        live_pend_d  = live_pend_q;
        out_evt_d    = out_evt_q;
        out_valid_d  = out_valid_q;
        out_src_d    = out_src_q;
        owner_d      = owner_q;
        owner_note_d = owner_note_q;
        drop_cnt_d   = drop_cnt_q;
        fifo_push    = 1'b0;
        fifo_pop     = 1'b0;
        keep         = 1'b0;

        echo_chg  = en && (echo_in != shadow_q);
        slot_free = !out_valid_q || out_ready;
        // A fresh strobe bypasses the slot so an idle voice sees it next cycle.
        live_has  = en && (live_valid || live_pend_q);
        live_cand = live_valid ? live_in : live_evt_q;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        // Newer live event overwrites any pending one.
        if (en && live_valid) begin
            live_pend_d = 1'b1;
            live_evt_d  = live_in;
        end

        if (en && slot_free) begin
            if (live_has) begin
                live_pend_d = 1'b0;
                keep = live_cand.on || (owner_q == OWN_LIVE && live_cand.note == owner_note_q);
                if (keep) begin
                    out_valid_d = 1'b1;
                    out_evt_d   = live_cand;
                    out_src_d   = 1'b0;
                    if (live_cand.on) begin
                        owner_d      = OWN_LIVE;
                        owner_note_d = live_cand.note;
                    end else begin
                        owner_d      = OWN_IDLE;
                    end
                end
            end else if (!fifo_empty) begin
                fifo_pop = 1'b1;
                case (owner_q)
                    OWN_LIVE: keep = 1'b0;
                    OWN_ECHO: keep = fifo_head.on || (fifo_head.note == owner_note_q);
                    default:  keep = fifo_head.on;
                endcase
                if (keep) begin
                    out_valid_d = 1'b1;
                    out_evt_d   = fifo_head;
                    out_src_d   = 1'b1;
                    if (fifo_head.on) begin
                        owner_d      = OWN_ECHO;
                        owner_note_d = fifo_head.note;
                    end else begin
                        owner_d      = OWN_IDLE;
                    end
                end
            end
        end

        // Shadow tracks the echo levels even when the event itself is dropped.
        if (echo_chg) begin
            shadow_d = echo_in;
            if (!fifo_full || fifo_pop) begin
                fifo_push = 1'b1;
            end else if (drop_cnt_q != {DROP_W{1'b1}}) begin
                drop_cnt_d = drop_cnt_q + DROP_W'(1);
            end
        end
    end

    // State registers; reset discards any in-flight or pending event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q     <= EVT_RESET;
            live_evt_q   <= EVT_RESET;
            live_pend_q  <= 1'b0;
            out_evt_q    <= EVT_RESET;
            out_valid_q  <= 1'b0;
            out_src_q    <= 1'b0;
            owner_q      <= OWN_IDLE;
            owner_note_q <= 7'd0;
            drop_cnt_q   <= '0;
        end else begin
            shadow_q     <= shadow_d;
            live_evt_q   <= live_evt_d;
            live_pend_q  <= live_pend_d;
            out_evt_q    <= out_evt_d;
            out_valid_q  <= out_valid_d;
            out_src_q    <= out_src_d;
            owner_q      <= owner_d;
            owner_note_q <= owner_note_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_on     = out_evt_q.on;
    assign out_note   = out_evt_q.note;
    assign out_vel    = out_evt_q.vel;
    assign out_pb     = out_evt_q.pb;
    assign out_cc1    = out_evt_q.cc1;
    assign out_cc1mod = out_evt_q.cc1mod;
    assign out_src    = out_src_q;
    assign owner      = owner_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_echo_voice_arbiter.sv
// Self-checking bench: vector table for ownership rules plus sequences for stall, overflow and reset.
// Latency: checks live 1-cycle issue and echo ordering.
// Backpressure: stalls out_ready to check hold, slot overwrite and FIFO overflow counting.
module tb_echo_voice_arbiter;
    import genmidi_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b1;
    logic       live_valid = 1'b0, live_on = 1'b0;
    logic [6:0] live_note = '0, live_vel = '0, live_cc1mod = '0;
    logic [8:0] live_pb = '0;
    logic [1:0] live_cc1 = '0;
    logic       echo_on = 1'b0;
    logic [6:0] echo_note = '0, echo_vel = '0, echo_cc1mod = 7'd127;
    logic [8:0] echo_pb = '0;
    logic [1:0] echo_cc1 = '0;
    logic       out_valid, out_ready = 1'b1;
    logic       out_on, out_src;
    logic [6:0] out_note, out_vel, out_cc1mod;
    logic [8:0] out_pb;
    logic [1:0] out_cc1, owner;
    logic [7:0] drop_cnt;

    int n_chk = 0;
    int n_pass = 0;

    logic [33:0] exp_q [$];

    echo_voice_arbiter #(.ECHO_DEPTH(4), .DROP_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .en(en),
        .live_valid(live_valid), .live_on(live_on), .live_note(live_note), .live_vel(live_vel),
        .live_pb(live_pb), .live_cc1(live_cc1), .live_cc1mod(live_cc1mod),
        .echo_on(echo_on), .echo_note(echo_note), .echo_vel(echo_vel),
        .echo_pb(echo_pb), .echo_cc1(echo_cc1), .echo_cc1mod(echo_cc1mod),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_on(out_on), .out_note(out_note), .out_vel(out_vel), .out_pb(out_pb),
        .out_cc1(out_cc1), .out_cc1mod(out_cc1mod), .out_src(out_src),
        .owner(owner), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       is_echo;
        bit       on;
        bit [6:0] note;
        bit [6:0] vel;
        bit [8:0] pb;
        bit [1:0] cc1;
        bit [6:0] cm;
        bit       exp_out;
        bit [1:0] exp_owner;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic vec_t mk(bit e, bit on, bit [6:0] note, bit [6:0] vel, bit xo, bit [1:0] xw);
        vec_t v;
        v.is_echo = e; v.on = on; v.note = note; v.vel = vel;
        v.pb = e ? 9'h100 : 9'h155;
        v.cc1 = e ? 2'd2 : 2'd1;
        v.cm = e ? 7'd100 : 7'd64;
        v.exp_out = xo; v.exp_owner = xw;
        return v;
    endfunction

    function automatic logic [33:0] pack(bit src, bit on, bit [6:0] note, bit [6:0] vel,
                                         bit [8:0] pb, bit [1:0] cc1, bit [6:0] cm);
        return {src, on, note, vel, pb, cc1, cm};
    endfunction

    task automatic set_echo(input bit on, input bit [6:0] note, input bit [6:0] vel,
                            input bit [8:0] pb, input bit [1:0] cc1, input bit [6:0] cm);
        echo_on = on; echo_note = note; echo_vel = vel;
        echo_pb = pb; echo_cc1 = cc1; echo_cc1mod = cm;
    endtask

    task automatic live_strobe(input bit on, input bit [6:0] note, input bit [6:0] vel);
        live_on = on; live_note = note; live_vel = vel;
        live_pb = 9'h155; live_cc1 = 2'd1; live_cc1mod = 7'd64;
        live_valid = 1'b1;
        step(1);
        live_valid = 1'b0;
    endtask

    // Scoreboard: every accepted transfer must match the oldest expected event.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {out_src, out_on, out_note}, 0);
            end else begin
                chk("out_event",
                    {out_src, out_on, out_note, out_vel, out_pb, out_cc1, out_cc1mod},
                    exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(0, 1, 60, 100, 1, 1);
        vecs[1]  = mk(0, 0, 60,   0, 1, 0);
        vecs[2]  = mk(0, 1, 60, 100, 1, 1);
        vecs[3]  = mk(1, 1, 60,  90, 0, 1);
        vecs[4]  = mk(1, 0, 60,  90, 0, 1);
        vecs[5]  = mk(0, 0, 60,   0, 1, 0);
        vecs[6]  = mk(1, 1, 64,  90, 1, 2);
        vecs[7]  = mk(0, 1, 67, 110, 1, 1);
        vecs[8]  = mk(1, 0, 64,  90, 0, 1);
        vecs[9]  = mk(0, 0, 67,   0, 1, 0);
        vecs[10] = mk(0, 0, 50,   0, 0, 0);
        vecs[11] = mk(0, 1, 62,  80, 1, 1);
        vecs[12] = mk(0, 0, 61,   0, 0, 1);
        vecs[13] = mk(0, 0, 62,   0, 1, 0);
        vecs[14] = mk(1, 1, 30,  70, 1, 2);
        vecs[15] = mk(1, 1, 31,  70, 1, 2);
        vecs[16] = mk(1, 0, 30,  70, 0, 2);
        vecs[17] = mk(1, 0, 31,  70, 1, 0);

        // Reset state.
        step(2);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_cc1mod", out_cc1mod, 127);
        chk("rst_note", out_note, 0);
        chk("rst_owner", owner, 0);
        chk("rst_drop", drop_cnt, 0);
        reset_n = 1'b1;
        step(3);
        chk("idle_after_rst", out_valid, 0);

        // Ownership table.
        for (int i = 0; i < 18; i++) begin
            vec_t v;
            v = vecs[i];
            if (v.exp_out) exp_q.push_back(pack(v.is_echo, v.on, v.note, v.vel, v.pb, v.cc1, v.cm));
            if (v.is_echo) begin
                set_echo(v.on, v.note, v.vel, v.pb, v.cc1, v.cm);
                step(1);
            end else begin
                live_strobe(v.on, v.note, v.vel);
                chk($sformatf("v%0d_latency", i), out_valid, v.exp_out);
            end
            step(4);
            chk($sformatf("v%0d_owner", i), owner, v.exp_owner);
            chk($sformatf("v%0d_drained", i), exp_q.size(), 0);
        end

        // Overflow under stall: 1 in output, 4 queued, 1 dropped.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) exp_q.push_back(pack(1, 1, 7'(40 + i), 10, 9'h100, 2'd2, 7'd100));
        for (int i = 0; i < 6; i++) begin
            set_echo(1, 7'(40 + i), 10, 9'h100, 2'd2, 7'd100);
            step(1);
        end
        step(1);
        chk("ovf_drop", drop_cnt, 1);
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_hold", {out_src, out_on, out_note, out_vel}, {1'b1, 1'b1, 7'd40, 7'd10});
            step(1);
        end
        out_ready = 1'b1;
        step(8);
        chk("ovf_drained", exp_q.size(), 0);
        chk("ovf_owner", owner, 2);
        exp_q.push_back(pack(1, 0, 44, 10, 9'h100, 2'd2, 7'd100));
        set_echo(0, 44, 10, 9'h100, 2'd2, 7'd100);
        step(5);
        chk("ovf_release_owner", owner, 0);

        // Simultaneous live and echo: live first.
        exp_q.push_back(pack(0, 1, 70, 100, 9'h155, 2'd1, 7'd64));
        live_strobe(1, 70, 100);
        step(4);
        exp_q.push_back(pack(0, 0, 70, 0, 9'h155, 2'd1, 7'd64));
        exp_q.push_back(pack(1, 1, 50, 90, 9'h100, 2'd2, 7'd100));
        set_echo(1, 50, 90, 9'h100, 2'd2, 7'd100);
        live_strobe(0, 70, 0);
        chk("simul_first_src", {out_valid, out_src}, 2'b10);
        step(1);
        chk("simul_second", {out_valid, out_src, out_note}, {1'b1, 1'b1, 7'd50});
        step(4);
        chk("simul_owner", owner, 2);

        // Two live events while stalled: last one wins.
        out_ready = 1'b0;
        exp_q.push_back(pack(0, 1, 71, 100, 9'h155, 2'd1, 7'd64));
        exp_q.push_back(pack(0, 1, 73, 100, 9'h155, 2'd1, 7'd64));
        live_strobe(1, 71, 100);
        live_strobe(1, 72, 100);
        live_strobe(1, 73, 100);
        step(2);
        chk("live_stall_hold", out_note, 71);
        out_ready = 1'b1;
        step(5);
        chk("live_ovr_drained", exp_q.size(), 0);
        chk("live_steal_owner", owner, 1);
        exp_q.push_back(pack(0, 0, 73, 0, 9'h155, 2'd1, 7'd64));
        live_strobe(0, 73, 0);
        step(4);
        chk("live_off_owner", owner, 0);

        // Disabled block ignores live strobes.
        en = 1'b0;
        live_strobe(1, 33, 100);
        step(2);
        chk("en_low_no_issue", out_valid, 0);
        en = 1'b1;
        step(3);
        chk("en_high_no_issue", out_valid, 0);

        // Reset with an event in the output register and entries queued.
        out_ready = 1'b0;
        set_echo(1, 20, 5, 9'h0, 2'd0, 7'd10);
        step(1);
        set_echo(1, 21, 5, 9'h0, 2'd0, 7'd10);
        step(1);
        set_echo(1, 22, 5, 9'h0, 2'd0, 7'd10);
        step(2);
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_drop", drop_cnt, 1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_cc1mod", out_cc1mod, 127);
        chk("arst_owner", owner, 0);
        chk("arst_drop", drop_cnt, 0);
        set_echo(0, 0, 0, 9'h0, 2'd0, 7'd127);
        out_ready = 1'b1;
        step(2);
        reset_n = 1'b1;
        step(6);
        chk("post_rst_quiet", out_valid, 0);
        exp_q.push_back(pack(0, 1, 55, 100, 9'h155, 2'd1, 7'd64));
        live_strobe(1, 55, 100);
        chk("post_rst_live", {out_valid, out_note}, {1'b1, 7'd55});
        step(4);
        chk("post_rst_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
